// File: rtl/vid_pkg.sv
// Shared types and the configuration legality rule for the raster timing generator.
package vid_pkg;

  localparam int CFG_CNT_W = 13;
  localparam int CFG_DIV_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } tg_state_t;

  typedef struct packed {
    logic [CFG_DIV_W-1:0] pcnt;
    logic [CFG_CNT_W-1:0] hsize;
    logic [CFG_CNT_W-1:0] hend;
    logic [CFG_CNT_W-1:0] hsync_start;
    logic [CFG_CNT_W-1:0] hsync_end;
    logic [CFG_CNT_W-1:0] vsize;
    logic [CFG_CNT_W-1:0] vend;
    logic [CFG_CNT_W-1:0] vsync_start;
    logic [CFG_CNT_W-1:0] vsync_end;
  } timing_cfg_t;

  // A raster is usable only if both axes have a visible area and sync windows inside the total.
  function automatic logic cfg_legal(input timing_cfg_t c);
    logic ok;
    ok = (c.hsize != '0) && (c.hsize <= c.hend) &&
         (c.vsize != '0) && (c.vsize <= c.vend) &&
         (c.hsync_start < c.hsync_end) && (c.hsync_end <= c.hend) &&
         (c.vsync_start < c.vsync_end) && (c.vsync_end <= c.vend);
    return ok;
  endfunction

endpackage

// File: rtl/vid_axis_counter.sv
// One raster axis: position counter with wrap, plus blank/sync decode of the next count.
module vid_axis_counter
  import vid_pkg::*;
#(
  parameter int CNT_W = 13
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clear,
  input  logic             i_advance,
  input  logic [CNT_W-1:0] i_size,
  input  logic [CNT_W-1:0] i_end,
  input  logic [CNT_W-1:0] i_sync_start,
  input  logic [CNT_W-1:0] i_sync_end,
  output logic [CNT_W-1:0] o_count,
  output logic [CNT_W-1:0] o_count_nxt,
  output logic             o_wrap,
  output logic             o_blank,
  output logic             o_sync_active
);

  logic [CNT_W-1:0] r_count;

  assign o_wrap = i_advance && (r_count == (i_end - CNT_W'(1)));

  always_comb begin
    o_count_nxt = r_count;
    if (i_clear || o_wrap) begin
      o_count_nxt = '0;
    end else if (i_advance) begin
      o_count_nxt = r_count + CNT_W'(1);
    end
  end

  // Decode from the next count so the registered flags line up with the registered count.
  assign o_blank       = (o_count_nxt >= i_size);
  assign o_sync_active = (o_count_nxt >= i_sync_start) && (o_count_nxt < i_sync_end);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else begin
      r_count <= o_count_nxt;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/vid_timing_gen.sv
// Programmable raster timing generator: pixel divider, H/V counters, sync/blank decode,
// frame-boundary config shadowing and line fetch / FIFO flush strobes.
module vid_timing_gen
  import vid_pkg::*;
#(
  parameter int   CNT_W     = CFG_CNT_W,
  parameter int   DIV_W     = CFG_DIV_W,
  parameter logic HSYNC_POL = 1'b1,
  parameter logic VSYNC_POL = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [DIV_W-1:0] pcnt,
  input  logic [CNT_W-1:0] hsize,
  input  logic [CNT_W-1:0] hend,
  input  logic [CNT_W-1:0] hsync_start,
  input  logic [CNT_W-1:0] hsync_end,
  input  logic [CNT_W-1:0] vsize,
  input  logic [CNT_W-1:0] vend,
  input  logic [CNT_W-1:0] vsync_start,
  input  logic [CNT_W-1:0] vsync_end,
  output logic             pix_tick,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             hblank,
  output logic             vblank,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             fetch_req,
  output logic [CNT_W-1:0] fetch_line,
  output logic             fifo_flush,
  output logic             frame_start,
  output logic             cfg_err
);

  tg_state_t        r_state;
  tg_state_t        w_state_nxt;
  timing_cfg_t      r_cfg;
  timing_cfg_t      w_cfg_in;
  timing_cfg_t      w_cfg_dec;
  logic [DIV_W-1:0] r_pdiv;

  logic             w_in_legal;
  logic             w_load;
  logic             w_tick;
  logic             w_run_nxt;
  logic             w_frame_wrap;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic             w_h_blank;
  logic             w_v_blank;
  logic             w_h_sync;
  logic             w_v_sync;
  logic             w_flush;
  logic             w_fetch;
  logic             w_last_line;
  logic [CNT_W-1:0] w_next_line;
  logic [CNT_W-1:0] w_hcnt;
  logic [CNT_W-1:0] w_vcnt;
  logic [CNT_W-1:0] w_hcnt_nxt;
  logic [CNT_W-1:0] w_vcnt_nxt;

  logic [DIV_W-1:0] w_pcnt;
  logic [CNT_W-1:0] w_hend;
  logic [CNT_W-1:0] w_vend;
  logic [CNT_W-1:0] w_hsize;
  logic [CNT_W-1:0] w_vsize;
  logic [CNT_W-1:0] w_dec_hsize;
  logic [CNT_W-1:0] w_dec_hss;
  logic [CNT_W-1:0] w_dec_hse;
  logic [CNT_W-1:0] w_dec_vsize;
  logic [CNT_W-1:0] w_dec_vss;
  logic [CNT_W-1:0] w_dec_vse;

  logic             r_hblank;
  logic             r_vblank;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_de;
  logic             r_fetch_req;
  logic [CNT_W-1:0] r_fetch_line;
  logic             r_fifo_flush;
  logic             r_frame_start;
  logic             r_cfg_err;

  always_comb begin
    w_cfg_in             = '0;
    w_cfg_in.pcnt        = CFG_DIV_W'(pcnt);
    w_cfg_in.hsize       = CFG_CNT_W'(hsize);
    w_cfg_in.hend        = CFG_CNT_W'(hend);
    w_cfg_in.hsync_start = CFG_CNT_W'(hsync_start);
    w_cfg_in.hsync_end   = CFG_CNT_W'(hsync_end);
    w_cfg_in.vsize       = CFG_CNT_W'(vsize);
    w_cfg_in.vend        = CFG_CNT_W'(vend);
    w_cfg_in.vsync_start = CFG_CNT_W'(vsync_start);
    w_cfg_in.vsync_end   = CFG_CNT_W'(vsync_end);
  end

  assign w_in_legal = cfg_legal(w_cfg_in);

  assign w_pcnt  = DIV_W'(r_cfg.pcnt);
  assign w_hend  = CNT_W'(r_cfg.hend);
  assign w_vend  = CNT_W'(r_cfg.vend);
  assign w_hsize = CNT_W'(r_cfg.hsize);
  assign w_vsize = CNT_W'(r_cfg.vsize);

  assign w_tick       = (r_state == RUN) && (r_pdiv == w_pcnt);
  assign w_frame_wrap = w_v_wrap;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (en) begin
          w_state_nxt = w_in_legal ? RUN : ERR;
          w_load      = w_in_legal;
        end
      end
      RUN: begin
        // Stop has priority over the shadow reload at a frame wrap.
        if (!en) begin
          w_state_nxt = IDLE;
        end else if (w_frame_wrap) begin
          w_state_nxt = w_in_legal ? RUN : ERR;
          w_load      = w_in_legal;
        end
      end
      ERR: begin
        if (!en) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_run_nxt = (w_state_nxt == RUN);

  // The first cycle of a new frame is decoded against the geometry being loaded with it.
  assign w_cfg_dec   = w_load ? w_cfg_in : r_cfg;
  assign w_dec_hsize = CNT_W'(w_cfg_dec.hsize);
  assign w_dec_hss   = CNT_W'(w_cfg_dec.hsync_start);
  assign w_dec_hse   = CNT_W'(w_cfg_dec.hsync_end);
  assign w_dec_vsize = CNT_W'(w_cfg_dec.vsize);
  assign w_dec_vss   = CNT_W'(w_cfg_dec.vsync_start);
  assign w_dec_vse   = CNT_W'(w_cfg_dec.vsync_end);

  vid_axis_counter #(
    .CNT_W (CNT_W)
  ) u_hcnt (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_clear       (~w_run_nxt),
    .i_advance     (w_tick),
    .i_size        (w_dec_hsize),
    .i_end         (w_hend),
    .i_sync_start  (w_dec_hss),
    .i_sync_end    (w_dec_hse),
    .o_count       (w_hcnt),
    .o_count_nxt   (w_hcnt_nxt),
    .o_wrap        (w_h_wrap),
    .o_blank       (w_h_blank),
    .o_sync_active (w_h_sync)
  );

  vid_axis_counter #(
    .CNT_W (CNT_W)
  ) u_vcnt (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_clear       (~w_run_nxt),
    .i_advance     (w_h_wrap),
    .i_size        (w_dec_vsize),
    .i_end         (w_vend),
    .i_sync_start  (w_dec_vss),
    .i_sync_end    (w_dec_vse),
    .o_count       (w_vcnt),
    .o_count_nxt   (w_vcnt_nxt),
    .o_wrap        (w_v_wrap),
    .o_blank       (w_v_blank),
    .o_sync_active (w_v_sync)
  );

  // With hsize == hend the counter never reaches hsize, so no flush or fetch is issued.
  assign w_flush     = w_tick && (w_hcnt_nxt == w_hsize);
  assign w_last_line = (w_vcnt == (w_vend - CNT_W'(1)));
  assign w_next_line = w_last_line ? '0 : (w_vcnt + CNT_W'(1));
  assign w_fetch     = w_flush && (((w_vcnt + CNT_W'(1)) < w_vsize) || w_last_line);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_cfg         <= '0;
      r_pdiv        <= '0;
      r_hblank      <= 1'b1;
      r_vblank      <= 1'b1;
      r_hsync       <= ~HSYNC_POL;
      r_vsync       <= ~VSYNC_POL;
      r_de          <= 1'b0;
      r_fetch_req   <= 1'b0;
      r_fetch_line  <= '0;
      r_fifo_flush  <= 1'b0;
      r_frame_start <= 1'b0;
      r_cfg_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cfg_err <= (w_state_nxt == ERR);
      if (w_load) begin
        r_cfg <= w_cfg_in;
      end
      r_pdiv <= ((r_state == RUN) && w_run_nxt && !w_tick) ? (r_pdiv + DIV_W'(1)) : '0;
      if (w_run_nxt) begin
        r_hblank      <= w_h_blank;
        r_vblank      <= w_v_blank;
        r_hsync       <= w_h_sync ? HSYNC_POL : ~HSYNC_POL;
        r_vsync       <= w_v_sync ? VSYNC_POL : ~VSYNC_POL;
        r_de          <= ~w_h_blank & ~w_v_blank;
        r_fifo_flush  <= w_flush;
        r_fetch_req   <= w_fetch;
        r_fetch_line  <= w_fetch ? w_next_line : '0;
        r_frame_start <= w_load;
      end else begin
        r_hblank      <= 1'b1;
        r_vblank      <= 1'b1;
        r_hsync       <= ~HSYNC_POL;
        r_vsync       <= ~VSYNC_POL;
        r_de          <= 1'b0;
        r_fifo_flush  <= 1'b0;
        r_fetch_req   <= 1'b0;
        r_fetch_line  <= '0;
        r_frame_start <= 1'b0;
      end
    end
  end

  assign pix_tick    = w_tick;
  assign x           = w_hcnt;
  assign y           = w_vcnt;
  assign hblank      = r_hblank;
  assign vblank      = r_vblank;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign fetch_req   = r_fetch_req;
  assign fetch_line  = r_fetch_line;
  assign fifo_flush  = r_fifo_flush;
  assign frame_start = r_frame_start;
  assign cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_vid_timing_gen.sv
// Bench for vid_timing_gen: directed raster scenarios plus random configurations, each
// cycle compared against a time-since-frame-start reference model.
module tb_vid_timing_gen;

  localparam int   CNT_W = 13;
  localparam int   DIV_W = 6;
  localparam logic HPOL  = 1'b1;
  localparam logic VPOL  = 1'b0;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             en = 1'b0;
  logic [DIV_W-1:0] pcnt = '0;
  logic [CNT_W-1:0] hsize = '0;
  logic [CNT_W-1:0] hend = '0;
  logic [CNT_W-1:0] hsync_start = '0;
  logic [CNT_W-1:0] hsync_end = '0;
  logic [CNT_W-1:0] vsize = '0;
  logic [CNT_W-1:0] vend = '0;
  logic [CNT_W-1:0] vsync_start = '0;
  logic [CNT_W-1:0] vsync_end = '0;

  logic             pix_tick;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             hblank;
  logic             vblank;
  logic             hsync;
  logic             vsync;
  logic             de;
  logic             fetch_req;
  logic [CNT_W-1:0] fetch_line;
  logic             fifo_flush;
  logic             frame_start;
  logic             cfg_err;

  always #5 clk = ~clk;

  vid_timing_gen #(
    .CNT_W     (CNT_W),
    .DIV_W     (DIV_W),
    .HSYNC_POL (HPOL),
    .VSYNC_POL (VPOL)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .pcnt        (pcnt),
    .hsize       (hsize),
    .hend        (hend),
    .hsync_start (hsync_start),
    .hsync_end   (hsync_end),
    .vsize       (vsize),
    .vend        (vend),
    .vsync_start (vsync_start),
    .vsync_end   (vsync_end),
    .pix_tick    (pix_tick),
    .x           (x),
    .y           (y),
    .hblank      (hblank),
    .vblank      (vblank),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .fetch_req   (fetch_req),
    .fetch_line  (fetch_line),
    .fifo_flush  (fifo_flush),
    .frame_start (frame_start),
    .cfg_err     (cfg_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: 0 idle, 1 running, 2 error; m_t = clocks since the current frame began.
  int m_st = 0;
  int m_t  = 0;
  int c_p, c_hs, c_he, c_hss, c_hse, c_vs, c_ve, c_vss, c_vse;
  int m_x = 0;
  int m_y = 0;

  task automatic check1(input string tag, input logic got, input logic exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkn(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_legal();
    return (hsize > 0) && (hsize <= hend) && (vsize > 0) && (vsize <= vend) &&
           (hsync_start < hsync_end) && (hsync_end <= hend) &&
           (vsync_start < vsync_end) && (vsync_end <= vend);
  endfunction

  task automatic latch_cfg();
    c_p = int'(pcnt);         c_hs = int'(hsize);       c_he = int'(hend);
    c_hss = int'(hsync_start); c_hse = int'(hsync_end);
    c_vs = int'(vsize);       c_ve = int'(vend);
    c_vss = int'(vsync_start); c_vse = int'(vsync_end);
  endtask

  task automatic model_edge();
    if (!reset_n) begin
      m_st = 0;
      m_t  = 0;
    end else begin
      case (m_st)
        0: if (en) begin
             if (in_legal()) begin latch_cfg(); m_t = 0; m_st = 1; end
             else m_st = 2;
           end
        1: if (!en) m_st = 0;
           else begin
             m_t++;
             if (m_t == (c_p + 1) * c_he * c_ve) begin
               if (in_legal()) begin latch_cfg(); m_t = 0; end
               else m_st = 2;
             end
           end
        default: if (!en) m_st = 0;
      endcase
    end
  endtask

  task automatic check_all();
    logic e_tick, e_hb, e_vb, e_hs, e_vs, e_de, e_ff, e_fr, e_fs, e_err;
    int   e_line, pd, pix;
    e_tick = 1'b0; e_hb = 1'b1; e_vb = 1'b1; e_hs = ~HPOL; e_vs = ~VPOL;
    e_de = 1'b0; e_ff = 1'b0; e_fr = 1'b0; e_fs = 1'b0; e_line = 0;
    m_x = 0; m_y = 0;
    if (m_st == 1) begin
      pd     = m_t % (c_p + 1);
      pix    = m_t / (c_p + 1);
      m_x    = pix % c_he;
      m_y    = pix / c_he;
      e_tick = (pd == c_p);
      e_hb   = (m_x >= c_hs);
      e_vb   = (m_y >= c_vs);
      e_hs   = (m_x >= c_hss && m_x < c_hse) ? HPOL : ~HPOL;
      e_vs   = (m_y >= c_vss && m_y < c_vse) ? VPOL : ~VPOL;
      e_de   = !e_hb && !e_vb;
      e_ff   = (pd == 0) && (m_x == c_hs);
      e_fr   = e_ff && ((m_y + 1 < c_vs) || (m_y == c_ve - 1));
      e_line = (m_y == c_ve - 1) ? 0 : m_y + 1;
      e_fs   = (m_t == 0);
    end
    e_err = (m_st == 2);
    check1("pix_tick", pix_tick, e_tick);
    checkn("x", 32'(x), 32'(m_x));
    checkn("y", 32'(y), 32'(m_y));
    check1("hblank", hblank, e_hb);
    check1("vblank", vblank, e_vb);
    check1("hsync", hsync, e_hs);
    check1("vsync", vsync, e_vs);
    check1("de", de, e_de);
    check1("fifo_flush", fifo_flush, e_ff);
    check1("fetch_req", fetch_req, e_fr);
    if (e_fr) checkn("fetch_line", 32'(fetch_line), 32'(e_line));
    check1("frame_start", frame_start, e_fs);
    check1("cfg_err", cfg_err, e_err);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic ref_cfg();
    pcnt = 6'd4; hsize = 13'd8; hend = 13'd15; hsync_start = 13'd10; hsync_end = 13'd13;
    vsize = 13'd4; vend = 13'd6; vsync_start = 13'd4; vsync_end = 13'd5;
  endtask

  task automatic rand_cfg();
    int he, ve, hss, vss;
    he  = int'($urandom_range(12, 1));
    ve  = int'($urandom_range(6, 1));
    hss = int'($urandom_range(he - 1, 0));
    vss = int'($urandom_range(ve - 1, 0));
    pcnt        = DIV_W'($urandom_range(3, 0));
    hend        = CNT_W'(he);
    hsize       = CNT_W'($urandom_range(he, 1));
    hsync_start = CNT_W'(hss);
    hsync_end   = CNT_W'($urandom_range(he, hss + 1));
    vend        = CNT_W'(ve);
    vsize       = CNT_W'($urandom_range(ve, 1));
    vsync_start = CNT_W'(vss);
    vsync_end   = CNT_W'($urandom_range(ve, vss + 1));
    if ($urandom_range(5, 0) == 0) hsync_end = CNT_W'(he + 1);
  endtask

  initial begin
    int n_tick, n_fetch, n_flush, n_hs, n_vs, n_de, k, n;
    int lines[$];

    // Reset values while reset_n is held low
    ref_cfg();
    #12;
    check_all();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 100; i++) step();

    // Reference raster: one full frame from the enable clock
    en = 1'b1;
    n_tick = 0; n_fetch = 0; n_flush = 0; n_hs = 0; n_vs = 0; n_de = 0;
    for (int i = 0; i < 450; i++) begin
      step();
      n_tick  += int'(pix_tick);
      n_flush += int'(fifo_flush);
      n_hs    += int'(hsync == HPOL);
      n_vs    += int'(vsync == VPOL);
      n_de    += int'(de);
      if (fetch_req) begin
        n_fetch++;
        lines.push_back(int'(fetch_line));
      end
    end
    checkn("frame_ticks", 32'(n_tick), 32'd90);
    checkn("frame_flushes", 32'(n_flush), 32'd6);
    checkn("frame_hsync_clks", 32'(n_hs), 32'd90);
    checkn("frame_vsync_clks", 32'(n_vs), 32'd75);
    checkn("frame_de_clks", 32'(n_de), 32'd160);
    checkn("frame_fetches", 32'(n_fetch), 32'd4);
    if (lines.size() == 4) begin
      checkn("fetch_seq0", 32'(lines[0]), 32'd1);
      checkn("fetch_seq1", 32'(lines[1]), 32'd2);
      checkn("fetch_seq2", 32'(lines[2]), 32'd3);
      checkn("fetch_seq3", 32'(lines[3]), 32'd0);
    end
    checkn("last_clk_x", 32'(x), 32'd14);
    checkn("last_clk_y", 32'(y), 32'd5);

    // Shadowing: hsize change on line 1 only takes effect from the next frame
    k = 0;
    while (!(m_st == 1 && m_y == 1) && k < 2000) begin step(); k++; end
    check1("bound_wait_y1", k < 2000, 1'b1);
    hsize = 13'd6;
    for (int i = 0; i < 30; i++) step();
    checkn("old_geom_x", 32'(x), 32'd6);
    check1("old_geom_hblank", hblank, 1'b0);
    k = 0;
    do begin step(); k++; end while (!(m_st == 1 && m_t == 0) && k < 2000);
    check1("bound_wait_frame", k < 2000, 1'b1);
    check1("new_frame_start", frame_start, 1'b1);
    for (int i = 0; i < 30; i++) step();
    checkn("new_geom_x", 32'(x), 32'd6);
    check1("new_geom_hblank", hblank, 1'b1);

    // Mid-frame disable and restart
    k = 0;
    while (!(m_st == 1 && m_x == 3 && m_y == 2) && k < 2000) begin step(); k++; end
    check1("bound_wait_x3y2", k < 2000, 1'b1);
    en = 1'b0;
    step();
    checkn("stop_x", 32'(x), 32'd0);
    checkn("stop_y", 32'(y), 32'd0);
    check1("stop_hblank", hblank, 1'b1);
    check1("stop_vsync", vsync, ~VPOL);
    en = 1'b1;
    step();
    check1("restart_frame_start", frame_start, 1'b1);
    for (int i = 0; i < 60; i++) step();

    // Illegal config at enable
    en = 1'b0;
    step();
    ref_cfg();
    hsync_end = 13'd16;
    en = 1'b1;
    step();
    check1("err_at_enable", cfg_err, 1'b1);
    n_tick = 0;
    for (int i = 0; i < 20; i++) begin step(); n_tick += int'(pix_tick); end
    checkn("err_no_ticks", 32'(n_tick), 32'd0);
    en = 1'b0;
    step();
    check1("err_cleared", cfg_err, 1'b0);

    // Illegal config picked up at a frame wrap
    hsync_end = 13'd13;
    en = 1'b1;
    k = 0;
    while (!(m_st == 1 && m_y == 2) && k < 2000) begin step(); k++; end
    check1("bound_wait_y2", k < 2000, 1'b1);
    vsync_end = 13'd7;
    k = 0;
    while (m_st != 2 && k < 2000) begin step(); k++; end
    check1("bound_wait_err", k < 2000, 1'b1);
    check1("err_after_wrap", cfg_err, 1'b1);
    en = 1'b0;
    step();
    vsync_end = 13'd5;

    // Stop on the same clock as a frame wrap
    en = 1'b1;
    k = 0;
    while (!(m_st == 1 && m_t == 449) && k < 2000) begin step(); k++; end
    check1("bound_wait_lastclk", k < 2000, 1'b1);
    en = 1'b0;
    step();
    check1("wrap_stop_frame_start", frame_start, 1'b0);
    step();

    // No horizontal blank: no flush or fetch ever
    hsize = 13'd15;
    en = 1'b1;
    n_flush = 0; n_fetch = 0;
    for (int i = 0; i < 500; i++) begin
      step();
      n_flush += int'(fifo_flush);
      n_fetch += int'(fetch_req);
    end
    checkn("nohblank_flushes", 32'(n_flush), 32'd0);
    checkn("nohblank_fetches", 32'(n_fetch), 32'd0);

    // Random geometries, mid-frame config changes and short enable drops
    for (int r = 0; r < 12; r++) begin
      en = 1'b0;
      step();
      rand_cfg();
      en = 1'b1;
      n = int'($urandom_range(600, 60));
      for (int i = 0; i < n; i++) begin
        step();
        if ($urandom_range(99, 0) == 0) rand_cfg();
        if ($urandom_range(299, 0) == 0) begin
          en = 1'b0;
          step();
          en = 1'b1;
        end
      end
    end

    // Asynchronous reset in the middle of a frame, then idle with en low
    en = 1'b0;
    step();
    ref_cfg();
    en = 1'b1;
    for (int i = 0; i < 137; i++) step();
    #2;
    reset_n = 1'b0;
    #1;
    m_st = 0;
    m_t  = 0;
    check_all();
    en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 100; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vid_timing_gen.md
Name: vid_timing_gen

Overview:
- Parametrised, programmable raster timing generator for the video controller family.
- Successor to the fixed-count pixel/horizontal counter logic: line and frame geometry, sync windows, sync polarity and pixel divider are all run-time programmable.
- Timing configuration is shadow-latched at frame boundaries, and the block adds vertical timing, pixel coordinates and line-fetch/flush strobes for the pixel FIFO and fetch engine.
- Sits between the register file (config inputs) and the RGB output / fetch state machines.

Parameters:
- CNT_W, 13: width of all horizontal/vertical geometry fields and of the x/y counters.
- DIV_W, 6: width of the pixel divider field pcnt.
- HSYNC_POL, 1: active level of hsync (1 = active high).
- VSYNC_POL, 1: active level of vsync.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- en  in  1  controller enable (cr.en)
- pcnt  in  DIV_W  pixel divider; one pixel every pcnt+1 clocks
- hsize  in  CNT_W  displayed pixels per line
- hend  in  CNT_W  total pixels per line
- hsync_start  in  CNT_W  first pixel of hsync
- hsync_end  in  CNT_W  first pixel after hsync
- vsize  in  CNT_W  displayed lines per frame
- vend  in  CNT_W  total lines per frame
- vsync_start  in  CNT_W  first line of vsync
- vsync_end  in  CNT_W  first line after vsync
- pix_tick  out  1  one-clock strobe, pixel advance
- x  out  CNT_W  current pixel column (hcnt)
- y  out  CNT_W  current line (vcnt)
- hblank  out  1  high when hcnt >= hsize
- vblank  out  1  high when vcnt >= vsize
- hsync  out  1  horizontal sync, polarity per HSYNC_POL
- vsync  out  1  vertical sync, polarity per VSYNC_POL
- de  out  1  display enable = ~hblank & ~vblank while running
- fetch_req  out  1  one-clock pulse requesting the next display line
- fetch_line  out  CNT_W  line index to fetch, valid with fetch_req
- fifo_flush  out  1  one-clock pulse at each hblank start
- frame_start  out  1  one-clock pulse when (x,y) becomes (0,0)
- cfg_err  out  1  shadowed config illegal

Behaviour:
Clock and reset:
- One clock; reset is asynchronous, active-low (reset_n) and clears all state.
- Reset and idle values: counters 0; x=y=0; pix_tick=0; hblank=vblank=1; de=0; hsync/vsync at their inactive levels; fetch_req=fifo_flush=frame_start=0; cfg_err=0; state IDLE.

States (IDLE, RUN, ERR):
- IDLE -> RUN when en=1 and the config sampled that cycle is legal.
- IDLE -> ERR when en=1 and the config is illegal.
- RUN -> IDLE when en=0. Synchronous stop on the next clock: counters return to 0 and outputs go to idle values, including mid-line or mid-frame.
- ERR -> IDLE when en=0. While in ERR, cfg_err=1 and outputs hold idle values.

Shadowing:
- All config inputs are copied to shadow registers on the IDLE->RUN clock and on the frame-wrap pixel tick (hcnt=hend-1 and vcnt=vend-1).
- Input changes at any other time have no effect.
- If the config latched at a frame wrap is illegal: go to ERR, with cfg_err asserted the next clock.

Legal config requires all of:
- 0 < hsize <= hend and 0 < vsize <= vend.
- hsync_start < hsync_end <= hend.
- vsync_start < vsync_end <= vend.

Pixel divider:
- pdiv counts 0..pcnt.
- pix_tick=1 for the clock in which pdiv==pcnt; pdiv wraps to 0 on that clock.
- pcnt=0 gives a tick every clock.

Counters:
- hcnt advances on pix_tick and wraps from hend-1 to 0.
- On that wrap, vcnt advances and wraps from vend-1 to 0.
- All arithmetic is CNT_W bits, unsigned; no count ever reaches hend or vend.

Decoded outputs:
- hblank, vblank, hsync, vsync and de are registered and decoded from the next-state counters, so they are valid in the same cycle as the matching x/y.
- hsync is active for hsync_start <= hcnt < hsync_end; vsync is active for vsync_start <= vcnt < vsync_end.

Strobes:
- fifo_flush pulses on the clock where hcnt becomes hsize.
- fetch_req pulses on that same clock when the next line is displayable: (vcnt+1 < vsize) or (vcnt == vend-1).
- fetch_line is vcnt+1, or 0 when vcnt == vend-1.
- frame_start pulses on the entry to RUN and on each frame wrap.

Edge and simultaneous cases:
- hsize == hend: no horizontal blank; fifo_flush and fetch_req never fire.
- en falling on the same clock as a frame wrap: the stop wins and no shadow update occurs.

Decomposition:
- Package vid_pkg holds:
  - timing_cfg_t: packed struct of the eight geometry fields plus pcnt.
  - tg_state_t: enum IDLE/RUN/ERR.
  - the cfg_legal() function.
- One sub-module, vid_axis_counter, instantiated twice (horizontal, vertical). It takes an advance input, size/end/sync_start/sync_end, and produces count, wrap, blank and sync_active.

Test Plan:
- Reset and idle: assert reset_n=0 mid-run -> all outputs go to reset values immediately; with en=0 after release, outputs stay idle for 100 clocks.
- Reference raster: pcnt=4, hsize=8, hend=15, hsync 10..13, vsize=4, vend=6, vsync 4..5, en=1 ->
  - pix_tick every 5 clocks;
  - line of 75 clocks, with hblank for x=8..14 and hsync for x=10..12;
  - frame of 450 clocks, with vblank for y=4..5 and vsync for y=4.
- Fetch strobes: same config -> fetch_req at x=8 on lines 0,1,2,5 with fetch_line 1,2,3,0; fifo_flush at x=8 on every line; no fetch_req on lines 3 and 4.
- Shadowing: change hsize to 6 at y=1 -> line geometry is unchanged until the next frame_start; from then on, hblank asserts at x=6.
- Illegal config: hsync_end=16 with hend=15 at en rise -> cfg_err=1, state ERR, no pix_tick; drop en -> cfg_err=0.
- Mid-frame disable: en=0 at x=3, y=2 -> on the next clock x=y=0, hblank=vblank=1, syncs inactive; re-enable -> frame_start pulses and counting restarts at (0,0).
